// File: rtl/lsu_access_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_access_sequencer
//
// Load/store sequencer between the CPU datapath and the data Memory port.
// Takes one byte/half/word load or store per request and turns it into
// Memory-port cycles:
//   - aligned requests become a single native access,
//   - misaligned requests are split into little-endian byte accesses
//     (or rejected with resp_err when splitting is disabled or the target is
//     the memory-mapped IO word),
//   - load data is assembled and sign/zero-extended here, so the Memory
//     ExtendSign input is held at 0.
// Exactly one response pulse is returned per accepted request.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_store          1 = store, 0 = load
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   req_wl             0 byte, 1 half, 2 word (3 behaves as word)
//   req_sign           sign-extend the load result
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load result (0 for stores and errors)
//   resp_err           misaligned request rejected
//   mem_addr/wdata/write_en/read/extend_sign/wl   Memory port drive
//   mem_rdata          Memory read data, combinational in the access cycle
// -----------------------------------------------------------------------------
module lsu_access_sequencer #(
  parameter bit          SPLIT_EN = 1'b1,
  parameter logic [31:0] IO_ADDR  = 32'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_wl,
  input  logic        req_sign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write_en,
  output logic        mem_read,
  output logic        mem_extend_sign,
  output logic [1:0]  mem_wl,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;

  logic        store_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  wl_q;
  logic        sign_q;
  logic        split_q;
  logic        err_q;
  logic [1:0]  cnt_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic [1:0]  req_wl_n;
  logic        misaligned;
  logic        reject;
  logic        last_access;

  // Width-based extension of the assembled load word.
  function automatic logic [31:0] extend_load(input logic [31:0] d,
                                              input logic [1:0]  wl,
                                              input logic        sgn);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic [31:0]        r;
    b8  = d[7:0];
    h16 = d[15:0];
    case (wl)
      2'd0:    r = sgn ? 32'(b8)  : {24'd0, d[7:0]};
      2'd1:    r = sgn ? 32'(h16) : {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Store byte lane k of a right-aligned store word, placed in bits 7:0.
  function automatic logic [31:0] store_lane(input logic [31:0] d,
                                             input logic [1:0]  k);
    return {24'd0, d[{k, 3'b000} +: 8]};
  endfunction

  // Request decode: width 3 is folded onto word before alignment checks.
  assign req_wl_n   = (req_wl == 2'd3) ? 2'd2 : req_wl;
  assign misaligned = ((req_wl_n == 2'd1) && req_addr[0]) ||
                      ((req_wl_n == 2'd2) && (req_addr[1:0] != 2'd0));
  assign reject     = misaligned &&
                      (!SPLIT_EN || (req_addr[31:2] == IO_ADDR[31:2]));
  assign accept     = req_valid && (state == IDLE);

  // Split halves take two byte cycles, split words four; aligned takes one.
  assign last_access = !split_q ||
                       (cnt_q == ((wl_q == 2'd1) ? 2'd1 : 2'd3));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = reject ? RESP : ACCESS;
      ACCESS:  if (last_access) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- request latch / byte counter / load assembly ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      store_q <= req_store;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wl_q    <= req_wl_n;
      sign_q  <= req_sign;
      split_q <= misaligned && !reject;
      err_q   <= reject;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      cnt_q <= cnt_q + 2'd1;
      if (!store_q) begin
        if (split_q) rdata_q[{cnt_q, 3'b000} +: 8] <= mem_rdata[7:0];
        else         rdata_q <= mem_rdata;
      end
    end
  end

  // ---- output decode ----
  always_comb begin
    req_ready    = (state == IDLE);
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_write_en = 1'b0;
    mem_read     = 1'b0;
    mem_wl       = '0;
    case (state)
      ACCESS: begin
        // cnt_q stays 0 for aligned accesses, so the sum is the plain address.
        mem_addr     = addr_q + {30'd0, cnt_q};
        mem_wl       = split_q ? 2'd0 : wl_q;
        mem_read     = !store_q;
        mem_write_en = store_q;
        if (store_q) mem_wdata = split_q ? store_lane(wdata_q, cnt_q) : wdata_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!store_q && !err_q) resp_rdata = extend_load(rdata_q, wl_q, sign_q);
      end
      default: ;
    endcase
  end

  assign mem_extend_sign = 1'b0;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
module tb_lsu_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // shared request fields, separate valids per instance
  logic        req_valid, req_valid_b;
  logic        req_store;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_wl;
  logic        req_sign;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write_en, mem_read, mem_extend_sign;
  logic [1:0]  mem_wl;

  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b;
  logic        mem_write_en_b, mem_read_b, mem_extend_sign_b;
  logic [1:0]  mem_wl_b;
  logic [31:0] mem_rdata_b;
  assign mem_rdata_b = 32'd0;

  lsu_access_sequencer #(.SPLIT_EN(1'b1), .IO_ADDR(32'd4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wl(req_wl), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read(mem_read), .mem_extend_sign(mem_extend_sign), .mem_wl(mem_wl),
    .mem_rdata(mem_rdata)
  );

  lsu_access_sequencer #(.SPLIT_EN(1'b0), .IO_ADDR(32'd4096)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wl(req_wl), .req_sign(req_sign),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_write_en(mem_write_en_b),
    .mem_read(mem_read_b), .mem_extend_sign(mem_extend_sign_b), .mem_wl(mem_wl_b),
    .mem_rdata(mem_rdata_b)
  );

  // Byte-addressed memory model, right-justified reads, little-endian.
  logic [7:0]  mem [0:8191];
  logic [12:0] a0, a1, a2, a3;
  assign a0 = mem_addr[12:0];
  assign a1 = mem_addr[12:0] + 13'd1;
  assign a2 = mem_addr[12:0] + 13'd2;
  assign a3 = mem_addr[12:0] + 13'd3;

  always_comb begin
    case (mem_wl)
      2'd0:    mem_rdata = {24'd0, mem[a0]};
      2'd1:    mem_rdata = {16'd0, mem[a1], mem[a0]};
      default: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_wl != 2'd0) mem[a1] <= mem_wdata[15:8];
      if (mem_wl[1]) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [1:0] wl; logic rd; logic we; logic [31:0] wdata; } acc_t;
  typedef struct { logic [12:0] idx; logic [7:0] val; } mchk_t;

  resp_t q_resp[$];
  resp_t q_b[$];
  acc_t  q_acc[$];
  mchk_t q_mem[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int tmo_req = 0;
  int tmo_seen = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: all comparisons happen here, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (tmo_req != tmo_seen) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: got %0d expired wait bounds, need 0", tmo_req - tmo_seen);
      tmo_seen = tmo_req;
    end
    if (rst) begin
      n_cmp++;
      if ({req_ready, resp_valid, resp_err, mem_read, mem_write_en, mem_extend_sign} !== 6'b100000 ||
          resp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wl !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b rd=%b we=%b es=%b rdata=%h addr=%h wdata=%h wl=%0d, need rdy=1 rest 0",
                 req_ready, resp_valid, resp_err, mem_read, mem_write_en, mem_extend_sign,
                 resp_rdata, mem_addr, mem_wdata, mem_wl);
      end
    end else begin
      n_cmp++;
      if ((mem_read && mem_write_en) || mem_extend_sign !== 1'b0) begin
        n_fail++;
        $display("FAIL bus_strobes: got rd=%b we=%b es=%b, need exclusive strobes and es=0",
                 mem_read, mem_write_en, mem_extend_sign);
      end
      if (mem_read || mem_write_en) begin
        acc_t e;
        n_cmp++;
        if (q_acc.size() == 0) begin
          n_fail++;
          $display("FAIL access_unexpected: got addr=%h wl=%0d rd=%b we=%b, need no access",
                   mem_addr, mem_wl, mem_read, mem_write_en);
        end else begin
          e = q_acc.pop_front();
          if (mem_addr !== e.addr || mem_wl !== e.wl || mem_read !== e.rd || mem_write_en !== e.we ||
              (e.we && mem_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL access: got addr=%h wl=%0d rd=%b we=%b wdata=%h, need addr=%h wl=%0d rd=%b we=%b wdata=%h",
                     mem_addr, mem_wl, mem_read, mem_write_en, mem_wdata, e.addr, e.wl, e.rd, e.we, e.wdata);
          end
        end
      end else begin
        n_cmp++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wl !== 2'd0) begin
          n_fail++;
          $display("FAIL bus_idle: got addr=%h wdata=%h wl=%0d, need all 0", mem_addr, mem_wdata, mem_wl);
        end
      end
      if (resp_valid) begin
        resp_t e;
        n_cmp++;
        if (q_resp.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got rdata=%h err=%b at cycle %0d, need no response", resp_rdata, resp_err, cyc);
        end else begin
          e = q_resp.pop_front();
          if (resp_rdata !== e.rdata || resp_err !== e.err || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL resp: got rdata=%h err=%b cycle=%0d, need rdata=%h err=%b cycle=%0d",
                     resp_rdata, resp_err, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
      n_cmp++;
      if (mem_read_b || mem_write_en_b) begin
        n_fail++;
        $display("FAIL b_strobes: got rd=%b we=%b, need 0 0", mem_read_b, mem_write_en_b);
      end
      if (resp_valid_b) begin
        resp_t e;
        n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_resp_unexpected: got err=%b at cycle %0d, need no response", resp_err_b, cyc);
        end else begin
          e = q_b.pop_front();
          if (resp_rdata_b !== e.rdata || resp_err_b !== e.err || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL b_resp: got rdata=%h err=%b cycle=%0d, need rdata=%h err=%b cycle=%0d",
                     resp_rdata_b, resp_err_b, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
    end
    while (q_mem.size() != 0) begin
      mchk_t m;
      m = q_mem.pop_front();
      n_cmp++;
      if (mem[m.idx] !== m.val) begin
        n_fail++;
        $display("FAIL mem_byte[%h]: got %h, need %h", m.idx, mem[m.idx], m.val);
      end
    end
  end

  task automatic acc(input logic [31:0] a, input logic [1:0] wl, input bit rd, input logic [31:0] wd);
    acc_t e;
    e.addr = a; e.wl = wl; e.rd = rd; e.we = !rd; e.wdata = wd;
    q_acc.push_back(e);
  endtask

  task automatic mchk(input logic [12:0] idx, input logic [7:0] v);
    mchk_t m;
    m.idx = idx; m.val = v;
    q_mem.push_back(m);
  endtask

  // Drive one request; expected response cycle = acceptance cycle + lat - 1.
  task automatic issue(input bit b, input bit st, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] wl, input bit sg, input logic [31:0] er,
                       input bit ee, input int lat, input bit rsp);
    int w;
    resp_t r;
    w = 0;
    @(negedge clk);
    while (!(b ? req_ready_b : req_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) tmo_req++;
    req_store = st; req_addr = a; req_wdata = d; req_wl = wl; req_sign = sg;
    if (b) req_valid_b = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    #1;
    r.rdata = er; r.err = ee; r.cyc = cyc + lat - 1;
    if (rsp) begin
      if (b) q_b.push_back(r); else q_resp.push_back(r);
    end
    // Scramble the request fields to show they were latched.
    req_valid = 1'b0; req_valid_b = 1'b0;
    req_store = ~st; req_addr = 32'hDEAD_BEE0; req_wdata = 32'h5A5A_5A5A;
    req_wl = 2'd0; req_sign = ~sg;
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    while ((q_resp.size() != 0 || q_acc.size() != 0 || q_b.size() != 0 || q_mem.size() != 0 ||
            !req_ready || !req_ready_b) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      tmo_req++;
      q_resp.delete(); q_acc.delete(); q_b.delete(); q_mem.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_valid_b = 1'b0;
    req_store = 1'b0; req_addr = '0; req_wdata = '0; req_wl = '0; req_sign = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // aligned store then aligned word load
    acc(32'h10, 2'd2, 1'b0, 32'h8000_1234);
    issue(0, 1, 32'h10, 32'h8000_1234, 2'd2, 0, 32'h0, 0, 2, 1); drain();
    acc(32'h10, 2'd2, 1'b1, 32'h0);
    issue(0, 0, 32'h10, 32'h0, 2'd2, 0, 32'h8000_1234, 0, 2, 1); drain();

    // aligned half/byte loads with sign and zero extension
    acc(32'h10, 2'd2, 1'b0, 32'hBEEF_0000);
    issue(0, 1, 32'h10, 32'hBEEF_0000, 2'd2, 0, 32'h0, 0, 2, 1); drain();
    acc(32'h12, 2'd1, 1'b1, 32'h0);
    issue(0, 0, 32'h12, 32'h0, 2'd1, 1, 32'hFFFF_BEEF, 0, 2, 1); drain();
    acc(32'h12, 2'd1, 1'b1, 32'h0);
    issue(0, 0, 32'h12, 32'h0, 2'd1, 0, 32'h0000_BEEF, 0, 2, 1); drain();
    acc(32'h13, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'h13, 32'h0, 2'd0, 1, 32'hFFFF_FFBE, 0, 2, 1); drain();
    acc(32'h13, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'h13, 32'h0, 2'd0, 0, 32'h0000_00BE, 0, 2, 1); drain();
    // width 3 behaves as word
    acc(32'h10, 2'd2, 1'b1, 32'h0);
    issue(0, 0, 32'h10, 32'h0, 2'd3, 1, 32'hBEEF_0000, 0, 2, 1); drain();

    // misaligned word store split into four bytes
    acc(32'h21, 2'd0, 1'b0, 32'hDD); acc(32'h22, 2'd0, 1'b0, 32'hCC);
    acc(32'h23, 2'd0, 1'b0, 32'hBB); acc(32'h24, 2'd0, 1'b0, 32'hAA);
    issue(0, 1, 32'h21, 32'hAABB_CCDD, 2'd2, 0, 32'h0, 0, 5, 1); drain();
    mchk(13'h21, 8'hDD); mchk(13'h22, 8'hCC); mchk(13'h23, 8'hBB); mchk(13'h24, 8'hAA);
    drain();
    acc(32'h21, 2'd0, 1'b1, 32'h0); acc(32'h22, 2'd0, 1'b1, 32'h0);
    acc(32'h23, 2'd0, 1'b1, 32'h0); acc(32'h24, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'h21, 32'h0, 2'd2, 1, 32'hAABB_CCDD, 0, 5, 1); drain();

    // misaligned half: split store then split load, both extensions
    acc(32'h23, 2'd0, 1'b0, 32'h80); acc(32'h24, 2'd0, 1'b0, 32'hFF);
    issue(0, 1, 32'h23, 32'h0000_FF80, 2'd1, 0, 32'h0, 0, 3, 1); drain();
    acc(32'h23, 2'd0, 1'b1, 32'h0); acc(32'h24, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'h23, 32'h0, 2'd1, 1, 32'hFFFF_FF80, 0, 3, 1); drain();
    acc(32'h23, 2'd0, 1'b1, 32'h0); acc(32'h24, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'h23, 32'h0, 2'd1, 0, 32'h0000_FF80, 0, 3, 1); drain();

    // split half wrapping past the top of the address space
    acc(32'hFFFF_FFFF, 2'd0, 1'b0, 32'h34); acc(32'h0, 2'd0, 1'b0, 32'h12);
    issue(0, 1, 32'hFFFF_FFFF, 32'h0000_1234, 2'd1, 0, 32'h0, 0, 3, 1); drain();
    acc(32'hFFFF_FFFF, 2'd0, 1'b1, 32'h0); acc(32'h0, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'hFFFF_FFFF, 32'h0, 2'd1, 0, 32'h0000_1234, 0, 3, 1); drain();

    // rejections: IO word on the splitting instance, any misaligned on the other
    issue(0, 1, 32'h1001, 32'h1234_5678, 2'd2, 0, 32'h0, 1, 1, 1); drain();
    issue(1, 0, 32'h02, 32'h0, 2'd2, 1, 32'h0, 1, 1, 1); drain();
    issue(1, 0, 32'h01, 32'h0, 2'd1, 1, 32'h0, 1, 1, 1); drain();

    // reset in the third byte of a split store
    acc(32'h20, 2'd2, 1'b0, 32'h0);
    issue(0, 1, 32'h20, 32'h0, 2'd2, 0, 32'h0, 0, 2, 1); drain();
    acc(32'h24, 2'd2, 1'b0, 32'h0);
    issue(0, 1, 32'h24, 32'h0, 2'd2, 0, 32'h0, 0, 2, 1); drain();
    acc(32'h21, 2'd0, 1'b0, 32'hDD); acc(32'h22, 2'd0, 1'b0, 32'hCC);
    issue(0, 1, 32'h21, 32'hAABB_CCDD, 2'd2, 0, 32'h0, 0, 5, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    drain();
    mchk(13'h21, 8'hDD); mchk(13'h22, 8'hCC); mchk(13'h23, 8'h00); mchk(13'h24, 8'h00);
    drain();
    acc(32'h21, 2'd0, 1'b1, 32'h0); acc(32'h22, 2'd0, 1'b1, 32'h0);
    acc(32'h23, 2'd0, 1'b1, 32'h0); acc(32'h24, 2'd0, 1'b1, 32'h0);
    issue(0, 0, 32'h21, 32'h0, 2'd2, 0, 32'h0000_CCDD, 0, 5, 1); drain();

    repeat (2) @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
